keypad_scanner: RTL and testbench
=================================

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 100000: clk cycles each column is driven; legal range 3..2^18-1.
REQ-002 SHALL have parameter DEBOUNCE_FRAMES, default 4: consecutive identical frames needed to accept a press or a release; legal range 1..15.
REQ-003 SHALL have parameter REPEAT_FRAMES, default 64: auto-repeat period in frames; used only when KEYPAD_REPEAT_EN is defined.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous reset, active low.
REQ-006 SHALL have port row  input  4  matrix rows, active low, externally pulled up, asynchronous to clk.
REQ-007 SHALL have port col  output  4  matrix column drive, active low, exactly one bit low at all times.
REQ-008 SHALL have port key  output  4  code of the accepted key, row_index*4 + col_index.
REQ-009 SHALL have port key_valid  output  1  one-cycle pulse when a key is accepted or repeated.
REQ-010 SHALL have port key_held  output  1  high while an accepted key is held.

Function
REQ-011 SHALL pass row through a 2-flop synchronizer; only the synchronized value is used.
REQ-012 SHALL hold each column low for SCAN_DIV cycles, stepping col 1110->1101->1011->0111->1110, wrapping after column 3.
REQ-013 SHALL sample the synchronized rows for the active column on that column's last dwell cycle.
REQ-014 SHALL define one frame as columns 0..3 (4*SCAN_DIV cycles); frame result = NONE, one key code, or MULTI.
REQ-015 SHALL treat MULTI (two or more low row/column intersections in a frame) as NONE.
REQ-016 SHALL run a debounce FSM evaluated once per frame end, with states IDLE, PRESS_CHK, HELD, RELEASE_CHK.
REQ-017 IDLE: a key result SHALL latch the candidate, set count=1 and go to PRESS_CHK; with DEBOUNCE_FRAMES=1 it SHALL instead accept immediately per REQ-018.
REQ-018 PRESS_CHK: a result equal to the candidate SHALL increment count; at count==DEBOUNCE_FRAMES it SHALL go to HELD, load key, and pulse key_valid on the same cycle.
REQ-019 PRESS_CHK: NONE SHALL return to IDLE; a different key SHALL restart with that key as candidate and count=1.
REQ-020 HELD: key_held SHALL be 1; the same key SHALL stay in HELD; any other result SHALL set count=1 and go to RELEASE_CHK.
REQ-021 RELEASE_CHK: the held key SHALL return to HELD with no new pulse; any other result SHALL increment count, and at DEBOUNCE_FRAMES SHALL go to IDLE with key_held cleared.
REQ-022 key SHALL retain its last accepted value after release.
REQ-023 Acceptance latency: for a key stable before a frame starts, key_valid SHALL assert on the last cycle of the DEBOUNCE_FRAMES-th complete frame.
REQ-024 The scan counter and column sequence SHALL free-run regardless of FSM state.

Reset
REQ-025 While rst_n is low: col=1110, key=0, key_valid=0, key_held=0, FSM=IDLE, all counters=0, synchronizer flops=1111.
REQ-026 Reset asserted mid-frame or mid-debounce SHALL discard the partial frame; scanning SHALL restart at column 0 on the first edge after deassertion.

Configuration
REQ-027 With KEYPAD_REPEAT_EN defined, HELD SHALL count frames and re-pulse key_valid (key unchanged) every REPEAT_FRAMES frames; the count SHALL reset on entering HELD, including from RELEASE_CHK.
REQ-028 With KEYPAD_REPEAT_EN undefined, key_valid SHALL pulse exactly once per accepted press and the repeat counter SHALL not exist.

Verification (SCAN_DIV=4, DEBOUNCE_FRAMES=3, REPEAT_FRAMES=5; frame = 16 cycles)
REQ-029 Reset release, no keys -> col cycles 1110,1101,1011,0111 every 4 cycles; key_valid never asserts.
REQ-030 Row1 held low whenever col2 is low, from before frame 0 -> key=6 and key_valid high for one cycle at the end of frame 2; key_held stays 1.
REQ-031 Key 6 held, then released for 1 frame, then pressed again -> key_held stays 1 and no second key_valid pulse; releasing for 3 frames -> key_held=0 and key=6 retained.
REQ-032 Keys 0 and 5 pressed together for 10 frames -> no key_valid pulse, key_held=0.
REQ-033 rst_n pulsed low during frame 1 of a key-3 press -> all outputs at reset values; acceptance occurs 3 full frames after deassertion.
REQ-034 KEYPAD_REPEAT_EN defined, key 9 held for 20 frames -> pulses at end of frame 2, then every 5 frames (frames 7, 12, 17); undefined -> single pulse only.

Source files
------------

// File: rtl/keypad_scanner.sv
// +----------------------------------------------------------------------------+
// | keypad_scanner                                                             |
// | 4x4 matrix keypad scanner: column drive, row sync, per-frame debounce.     |
// | Optional build macro: KEYPAD_REPEAT_EN enables auto-repeat while held.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module keypad_scanner #(
  parameter int SCAN_DIV        = 100000,
  parameter int DEBOUNCE_FRAMES = 4,
  parameter int REPEAT_FRAMES   = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key,
  output logic       key_valid,
  output logic       key_held
);

  localparam logic [1:0] ST_IDLE        = 2'd0;
  localparam logic [1:0] ST_PRESS_CHK   = 2'd1;
  localparam logic [1:0] ST_HELD        = 2'd2;
  localparam logic [1:0] ST_RELEASE_CHK = 2'd3;

  localparam logic [17:0] DIV_LAST = 18'(SCAN_DIV - 1);
  localparam logic [3:0]  DB_LAST  = 4'(DEBOUNCE_FRAMES - 1);

  generate
    if (SCAN_DIV < 3 || SCAN_DIV > 262143 || DEBOUNCE_FRAMES < 1 ||
        DEBOUNCE_FRAMES > 15 || REPEAT_FRAMES < 1) begin : g_param_error
      $error("keypad_scanner: parameter out of legal range");
    end
  endgenerate

  // Row synchronizer
  logic [3:0] row_meta;
  logic [3:0] row_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_meta <= 4'hF;
      row_sync <= 4'hF;
    end else begin
      row_meta <= row;
      row_sync <= row_meta;
    end
  end

  // Free-running column scan
  logic [17:0] div_cnt;
  logic [1:0]  col_idx;
  logic        col_end;
  logic        frame_end;

  assign col_end   = (div_cnt == DIV_LAST);
  assign frame_end = col_end && (col_idx == 2'd3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      col_idx <= 2'd0;
    end else if (col_end) begin
      div_cnt <= '0;
      col_idx <= col_idx + 2'd1;
    end else begin
      div_cnt <= div_cnt + 18'd1;
    end
  end

  // Frame accumulation: intersection count saturates at 2 (MULTI)
  logic [3:0] row_hit;
  logic [2:0] hits;
  logic [1:0] row_enc;
  logic [1:0] base_cnt;
  logic [2:0] sum_cnt;
  logic [1:0] acc_cnt;
  logic [1:0] acc_cnt_next;
  logic [3:0] acc_code;
  logic [3:0] acc_code_next;
  logic       res_key;
  logic [3:0] res_code;

  assign row_hit = ~row_sync;
  assign hits    = {2'b00, row_hit[0]} + {2'b00, row_hit[1]} +
                   {2'b00, row_hit[2]} + {2'b00, row_hit[3]};

  always_comb begin
    row_enc = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (row_hit[i]) row_enc = 2'(i);
    end
  end

  always_comb begin
    base_cnt      = (col_idx == 2'd0) ? 2'd0 : acc_cnt;
    sum_cnt       = {1'b0, base_cnt} + hits;
    acc_cnt_next  = (sum_cnt >= 3'd2) ? 2'd2 : sum_cnt[1:0];
    acc_code_next = acc_code;
    if (base_cnt == 2'd0 && hits == 3'd1) begin
      acc_code_next = {row_enc, col_idx};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_cnt  <= 2'd0;
      acc_code <= 4'd0;
    end else if (col_end) begin
      acc_cnt  <= acc_cnt_next;
      acc_code <= acc_code_next;
    end
  end

  assign res_key  = frame_end && (acc_cnt_next == 2'd1);
  assign res_code = acc_code_next;

  // Debounce FSM
  logic [1:0] state;
  logic [1:0] state_next;
  logic [3:0] cand;
  logic [3:0] cand_next;
  logic [3:0] cnt;
  logic [3:0] cnt_next;
  logic [3:0] key_reg;
  logic [3:0] key_next;
  logic       accept;
  logic       repeat_pulse;

`ifdef KEYPAD_REPEAT_EN
  localparam int REP_W = $clog2(REPEAT_FRAMES + 1);
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_FRAMES - 1);
  logic [REP_W-1:0] rep_cnt;
  logic [REP_W-1:0] rep_next;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      cand    <= 4'd0;
      cnt     <= 4'd0;
      key_reg <= 4'd0;
`ifdef KEYPAD_REPEAT_EN
      rep_cnt <= '0;
`endif
    end else begin
      state   <= state_next;
      cand    <= cand_next;
      cnt     <= cnt_next;
      key_reg <= key_next;
`ifdef KEYPAD_REPEAT_EN
      rep_cnt <= rep_next;
`endif
    end
  end

  always_comb begin
    state_next   = state;
    cand_next    = cand;
    cnt_next     = cnt;
    key_next     = key_reg;
    accept       = 1'b0;
    repeat_pulse = 1'b0;
`ifdef KEYPAD_REPEAT_EN
    rep_next     = rep_cnt;
`endif
    if (frame_end) begin
      case (state)
        ST_IDLE: begin
          if (res_key) begin
            if (DEBOUNCE_FRAMES == 1) begin
              state_next = ST_HELD;
              key_next   = res_code;
              accept     = 1'b1;
`ifdef KEYPAD_REPEAT_EN
              rep_next   = '0;
`endif
            end else begin
              state_next = ST_PRESS_CHK;
              cand_next  = res_code;
              cnt_next   = 4'd1;
            end
          end
        end
        ST_PRESS_CHK: begin
          if (res_key && res_code == cand) begin
            if (cnt == DB_LAST) begin
              state_next = ST_HELD;
              key_next   = cand;
              accept     = 1'b1;
`ifdef KEYPAD_REPEAT_EN
              rep_next   = '0;
`endif
            end else begin
              cnt_next = cnt + 4'd1;
            end
          end else if (res_key) begin
            cand_next = res_code;
            cnt_next  = 4'd1;
          end else begin
            state_next = ST_IDLE;
          end
        end
        ST_HELD: begin
          if (res_key && res_code == key_reg) begin
`ifdef KEYPAD_REPEAT_EN
            if (rep_cnt == REP_LAST) begin
              repeat_pulse = 1'b1;
              rep_next     = '0;
            end else begin
              rep_next = rep_cnt + 1'b1;
            end
`endif
          end else if (DEBOUNCE_FRAMES == 1) begin
            state_next = ST_IDLE;
          end else begin
            state_next = ST_RELEASE_CHK;
            cnt_next   = 4'd1;
          end
        end
        default: begin
          if (res_key && res_code == key_reg) begin
            state_next = ST_HELD;
`ifdef KEYPAD_REPEAT_EN
            rep_next   = '0;
`endif
          end else if (cnt == DB_LAST) begin
            state_next = ST_IDLE;
          end else begin
            cnt_next = cnt + 4'd1;
          end
        end
      endcase
    end
  end

  // Outputs: the accepted code is visible on the same cycle as its pulse
  always_comb begin
    col       = ~(4'b0001 << col_idx);
    key       = accept ? res_code : key_reg;
    key_valid = accept | repeat_pulse;
    key_held  = (state == ST_HELD) || (state == ST_RELEASE_CHK);
  end

endmodule

`default_nettype wire

// File: tb/tb_keypad_scanner.sv
// +----------------------------------------------------------------------------+
// | tb_keypad_scanner                                                          |
// | Keypad matrix emulation with a frame-level behavioural reference model.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_keypad_scanner;

  localparam int SCAN_DIV = 4;
  localparam int DB       = 3;
  localparam int RF       = 5;
  localparam int FRAME    = 4 * SCAN_DIV;
`ifdef KEYPAD_REPEAT_EN
  localparam bit REPEAT_ON = 1'b1;
`else
  localparam bit REPEAT_ON = 1'b0;
`endif

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [3:0]  key;
  logic        key_valid;
  logic        key_held;
  logic [15:0] pressed = '0;

  int n_checks = 0;
  int n_fail   = 0;
  int k        = 0;
  int npulse   = 0;

  // Reference model state (frame granularity)
  bit m_held   = 1'b0;
  int m_hkey   = 0;
  int m_last   = 0;
  int m_cand   = 0;
  int m_streak = 0;
  int m_miss   = 0;
  int m_rep    = 0;

  always #5 clk = ~clk;

  // Switch matrix: a pressed key shorts its row to its column
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !col[c]) row[r] = 1'b0;
  end

  keypad_scanner #(
    .SCAN_DIV(SCAN_DIV),
    .DEBOUNCE_FRAMES(DB),
    .REPEAT_FRAMES(RF)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .row(row),
    .col(col),
    .key(key),
    .key_valid(key_valid),
    .key_held(key_held)
  );

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, k);
    end
  endtask

  function automatic int frame_result(input logic [15:0] p);
    int n = 0;
    int code = -1;
    for (int i = 0; i < 16; i++) begin
      if (p[i]) begin
        n++;
        code = i;
      end
    end
    return (n == 1) ? code : -1;
  endfunction

  task automatic model_reset();
    m_held = 1'b0; m_hkey = 0; m_last = 0; m_cand = 0;
    m_streak = 0; m_miss = 0; m_rep = 0;
  endtask

  task automatic step();
    int r;
    bit pulse;
    logic [3:0] held_before;
    @(negedge clk);
    k++;
    check("col", col, ~(4'b0001 << ((k % FRAME) / SCAN_DIV)));
    if (key_valid) npulse++;
    if (k % FRAME == FRAME - 1) begin
      r = frame_result(pressed);
      pulse = 1'b0;
      held_before = {3'b000, m_held};
      if (!m_held) begin
        if (r >= 0) begin
          if (m_streak > 0 && r == m_cand) m_streak++;
          else begin
            m_cand = r;
            m_streak = 1;
          end
          if (m_streak == DB) begin
            m_held = 1'b1; m_hkey = r; m_last = r; pulse = 1'b1;
            m_rep = 0; m_miss = 0;
          end
        end else m_streak = 0;
      end else if (r == m_hkey) begin
        if (m_miss > 0) begin
          m_miss = 0;
          m_rep = 0;
        end else if (REPEAT_ON) begin
          m_rep++;
          if (m_rep == RF) begin
            pulse = 1'b1;
            m_rep = 0;
          end
        end
      end else begin
        m_miss++;
        if (m_miss == DB) begin
          m_held = 1'b0; m_streak = 0; m_miss = 0;
        end
      end
      check("key_valid_frame_end", {3'b000, key_valid}, {3'b000, pulse});
      check("key_held_frame_end", {3'b000, key_held}, held_before);
      check("key_frame_end", key, 4'(m_last));
    end else begin
      check("key_valid_mid", {3'b000, key_valid}, 4'd0);
      check("key_held", {3'b000, key_held}, {3'b000, m_held});
      check("key", key, 4'(m_last));
    end
  endtask

  task automatic reset_outputs(input string tag);
    check({tag, "_col"}, col, 4'b1110);
    check({tag, "_key"}, key, 4'd0);
    check({tag, "_valid"}, {3'b000, key_valid}, 4'd0);
    check({tag, "_held"}, {3'b000, key_held}, 4'd0);
  endtask

  // Asserts reset at the current time, holds it, releases on a falling edge
  task automatic do_reset(input logic [15:0] p);
    rst_n = 1'b0;
    pressed = p;
    #1;
    reset_outputs("rst_async");
    repeat (2) begin
      @(negedge clk);
      reset_outputs("rst_hold");
    end
    @(negedge clk);
    rst_n = 1'b1;
    k = 0;
    model_reset();
  endtask

  task automatic run_frames(input logic [15:0] p, input int n);
    pressed = p;
    repeat (n * FRAME) step();
  endtask

  localparam logic [15:0] KEY0 = 16'h0001;
  localparam logic [15:0] KEY3 = 16'h0008;
  localparam logic [15:0] KEY5 = 16'h0020;
  localparam logic [15:0] KEY6 = 16'h0040;
  localparam logic [15:0] KEY9 = 16'h0200;

  initial begin
    logic [15:0] p;
    int a;
    int b;

    #3;
    // Idle scanning, no keys
    do_reset('0);
    run_frames('0, 2);

    // Key 6 from before frame 0: accepted at end of frame 2
    do_reset(KEY6);
    npulse = 0;
    run_frames(KEY6, 4);
    check("key6_pulses", 4'(npulse), 4'd1);
    check("key6_code", key, 4'd6);
    check("key6_held", {3'b000, key_held}, 4'd1);

    // One-frame bounce keeps the key held without a second pulse
    npulse = 0;
    run_frames('0, 1);
    run_frames(KEY6, 2);
    check("bounce_no_pulse", 4'(npulse), 4'd0);
    check("bounce_held", {3'b000, key_held}, 4'd1);

    // Full release
    run_frames('0, 3);
    check("release_held", {3'b000, key_held}, 4'd0);
    check("release_key_kept", key, 4'd6);

    // Two keys together are ignored
    npulse = 0;
    run_frames(KEY0 | KEY5, 10);
    check("multi_pulses", 4'(npulse), 4'd0);
    check("multi_held", {3'b000, key_held}, 4'd0);

    // Reset during frame 1 of a key-3 press
    run_frames(KEY3, 1);
    repeat (7) step();
    do_reset(KEY3);
    npulse = 0;
    run_frames(KEY3, 4);
    check("rst_key3_pulses", 4'(npulse), 4'd1);
    check("rst_key3_code", key, 4'd3);
    run_frames('0, 4);

    // Long hold of key 9: auto-repeat when enabled
    npulse = 0;
    run_frames(KEY9, 20);
    check("key9_pulses", 4'(npulse), REPEAT_ON ? 4'd4 : 4'd1);
    check("key9_code", key, 4'd9);
    run_frames('0, 4);

    // Random press patterns held for whole frames
    p = '0;
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0: p = '0;
        1: p = 16'h0001 << $urandom_range(0, 15);
        2: p = p;
        default: begin
          a = int'($urandom_range(0, 15));
          b = (a + int'($urandom_range(1, 15))) % 16;
          p = (16'h0001 << a) | (16'h0001 << b);
        end
      endcase
      run_frames(p, int'($urandom_range(1, 5)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
